// File: rtl/qspi_host.sv
// Host (initiator) end of the 4-bit serial link: write phase, optional turnaround,
// read phase, all inside a single cs_n-low window. Nibbles travel MSB-first.
module qspi_host #(
    parameter int DIV  = 2,
    parameter int DW   = 32,
    parameter int TURN = 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic [$clog2(DW/4+1)-1:0]       wr_len,
    input  logic [$clog2(DW/4+1)-1:0]       rd_len,
    input  logic [DW-1:0]                   wr_data,
    output logic                            busy,
    output logic                            done,
    output logic [DW-1:0]                   rd_data,
    output logic                            sck,
    output logic                            cs_n,
    output logic [3:0]                      q_out,
    output logic                            q_oe,
    input  logic [3:0]                      q_in
);

    localparam int NMAX  = DW / 4;
    localparam int LW    = $clog2(NMAX + 1);
    localparam int NCMAX = (NMAX > TURN) ? NMAX : TURN;
    localparam int NW    = $clog2(NCMAX + 1);
    localparam int CW    = $clog2(DIV + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_TURN,
        ST_READ,
        ST_HOLD,
        ST_GAP
    } state_t;

    state_t          state, state_d;
    logic [CW-1:0]   cnt, cnt_d;
    logic            ph, ph_d;
    logic [NW-1:0]   nib, nib_d;
    logic [DW-1:0]   wr_sr, wr_sr_d, wr_sr_shift;
    logic [LW-1:0]   rd_len_q, rd_len_d;
    logic [DW-1:0]   rd_data_d;
    logic            sck_d, cs_n_d, q_oe_d, done_d, busy_d;
    logic [3:0]      q_out_d;

    logic [LW-1:0]   wr_clamp, rd_clamp, rd_sel;
    logic            half_end;
    state_t          post_wr_state;
    logic [NW-1:0]   post_wr_nib;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            ph       <= 1'b0;
            nib      <= '0;
            wr_sr    <= '0;
            rd_len_q <= '0;
            rd_data  <= '0;
            sck      <= 1'b0;
            cs_n     <= 1'b1;
            q_out    <= '0;
            q_oe     <= 1'b0;
            done     <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            ph       <= ph_d;
            nib      <= nib_d;
            wr_sr    <= wr_sr_d;
            rd_len_q <= rd_len_d;
            rd_data  <= rd_data_d;
            sck      <= sck_d;
            cs_n     <= cs_n_d;
            q_out    <= q_out_d;
            q_oe     <= q_oe_d;
            done     <= done_d;
            busy     <= busy_d;
        end
    end

    always_comb begin
        wr_clamp    = (wr_len > LW'(NMAX)) ? LW'(NMAX) : wr_len;
        rd_clamp    = (rd_len > LW'(NMAX)) ? LW'(NMAX) : rd_len;
        rd_sel      = (state == ST_IDLE) ? rd_clamp : rd_len_q;
        half_end    = (cnt == CW'(DIV - 1));
        wr_sr_shift = wr_sr << 4;
        // Where to go once the write phase is over (or skipped entirely).
        if (rd_sel == '0) begin
            post_wr_state = ST_HOLD;
            post_wr_nib   = '0;
        end else if (TURN > 0) begin
            post_wr_state = ST_TURN;
            post_wr_nib   = NW'(TURN);
        end else begin
            post_wr_state = ST_READ;
            post_wr_nib   = NW'(rd_sel);
        end
    end

    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        ph_d      = ph;
        nib_d     = nib;
        wr_sr_d   = wr_sr;
        rd_len_d  = rd_len_q;
        rd_data_d = rd_data;
        sck_d     = sck;
        cs_n_d    = cs_n;
        q_out_d   = q_out;
        q_oe_d    = q_oe;
        done_d    = 1'b0;
        busy_d    = busy;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    busy_d    = 1'b1;
                    cs_n_d    = 1'b0;
                    sck_d     = 1'b0;
                    cnt_d     = '0;
                    ph_d      = 1'b0;
                    wr_sr_d   = wr_data;
                    rd_len_d  = rd_clamp;
                    rd_data_d = '0;
                    if (wr_clamp != '0) begin
                        state_d = ST_WRITE;
                        nib_d   = NW'(wr_clamp);
                        q_out_d = wr_data[DW-1 -: 4];
                        q_oe_d  = 1'b1;
                    end else begin
                        state_d = post_wr_state;
                        nib_d   = post_wr_nib;
                        q_out_d = '0;
                        q_oe_d  = 1'b0;
                    end
                end
            end

            ST_WRITE, ST_TURN, ST_READ: begin
                cnt_d = cnt + CW'(1);
                if (half_end) begin
                    cnt_d = '0;
                    if (!ph) begin
                        ph_d  = 1'b1;
                        sck_d = 1'b1;
                    end else begin
                        ph_d  = 1'b0;
                        sck_d = 1'b0;
                        nib_d = nib - NW'(1);
                        if (state == ST_READ)
                            rd_data_d = (rd_data << 4) | DW'(q_in);
                        if (nib == NW'(1)) begin
                            case (state)
                                ST_WRITE: begin
                                    state_d = post_wr_state;
                                    nib_d   = post_wr_nib;
                                    // Last write nibble stays driven through HOLD.
                                    if (post_wr_state != ST_HOLD) begin
                                        q_out_d = '0;
                                        q_oe_d  = 1'b0;
                                    end
                                end
                                ST_TURN: begin
                                    state_d = ST_READ;
                                    nib_d   = NW'(rd_len_q);
                                end
                                default: state_d = ST_HOLD;
                            endcase
                        end else if (state == ST_WRITE) begin
                            wr_sr_d = wr_sr_shift;
                            q_out_d = wr_sr_shift[DW-1 -: 4];
                        end
                    end
                end
            end

            ST_HOLD: begin
                cnt_d = cnt + CW'(1);
                if (half_end) begin
                    cnt_d   = '0;
                    cs_n_d  = 1'b1;
                    done_d  = 1'b1;
                    q_out_d = '0;
                    q_oe_d  = 1'b0;
                    state_d = ST_GAP;
                end
            end

            ST_GAP: begin
                // The done cycle plus DIV further clk keep busy asserted.
                cnt_d = cnt + CW'(1);
                if (cnt == CW'(DIV)) begin
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

endmodule
